// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction-fetch (I) and load/store (D) requesters.
// Steers 1-cycle read data back to the issuing port and answers misaligned D accesses with an error.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_f3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [2:0]  mem_f3,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    owner_t     owner, owner_next;
    logic       err_pend, err_pend_next;
    logic [3:0] starve_cnt, starve_next;
    logic       mis, d_mem, i_win, d_win;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= OWN_NONE;
            err_pend   <= 1'b0;
            starve_cnt <= '0;
        end else begin
            owner      <= owner_next;
            err_pend   <= err_pend_next;
            starve_cnt <= starve_next;
        end
    end

    always_comb begin
        mis   = (d_f3[1:0] == 2'b10 && d_addr[1:0] != 2'b00) ||
                (d_f3[1:0] == 2'b01 && d_addr[0]);
        d_mem = d_req && !mis;
        // I also wins whenever D is absent or only erroring, since an error grant needs no memory slot
        i_win = i_req && (!d_mem || starve_cnt == LIMIT);
        d_win = d_mem && !i_win;

        i_gnt     = i_win;
        d_gnt     = d_win || (d_req && mis);
        mem_req   = i_win || d_win;
        mem_we    = d_win && d_we;
        mem_f3    = d_win ? d_f3 : 3'b010;
        mem_addr  = d_win ? d_addr : i_addr;
        mem_wdata = d_win ? d_wdata : '0;

        owner_next = OWN_NONE;
        if (i_win)
            owner_next = OWN_I;
        else if (d_win)
            owner_next = OWN_D;
        err_pend_next = d_req && mis;

        starve_next = starve_cnt;
        if (!i_req || i_win)
            starve_next = '0;
        else if (starve_cnt != LIMIT)
            starve_next = starve_cnt + 4'd1;
    end

    // Responses decode the registered owner so reset kills a pending response at once
    always_comb begin
        i_rvalid = (owner == OWN_I);
        i_rdata  = (owner == OWN_I) ? mem_rdata : '0;
        d_rvalid = (owner == OWN_D) || err_pend;
        d_err    = err_pend;
        d_rdata  = (owner == OWN_D) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grants checked inline, responses checked by a scoreboard monitor.
module tb_mem_port_arbiter;

    logic        clk, reset;
    logic        i_req, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [2:0]  d_f3;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we;
    logic [2:0]  mem_f3;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    typedef struct packed {
        logic        err;
        logic        chk;
        logic [31:0] data;
    } d_resp_t;

    logic [31:0] i_exp[$];
    d_resp_t     d_exp[$];
    int          total  = 0;
    int          passed = 0;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_f3(d_f3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_f3(mem_f3), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memval(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    always @(posedge clk)
        mem_rdata <= (mem_req && !mem_we) ? memval(mem_addr) : 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (i_rvalid) begin
                if (i_exp.size() == 0) chk("i_rvalid_unexpected", 32'(i_rvalid), 32'h0);
                else chk("i_rdata", i_rdata, i_exp.pop_front());
            end
            if (d_rvalid) begin
                if (d_exp.size() == 0) chk("d_rvalid_unexpected", 32'(d_rvalid), 32'h0);
                else begin
                    d_resp_t e;
                    e = d_exp.pop_front();
                    chk("d_err", 32'(d_err), 32'(e.err));
                    if (e.chk) chk("d_rdata", d_rdata, e.data);
                end
            end
        end
    end

    task automatic idle_inputs();
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_f3 = 0; d_addr = 0; d_wdata = 0;
    endtask

    task automatic at_neg(input logic ei, input logic ed, input logic em, input logic ri, input logic rd);
        @(negedge clk);
        chk("i_gnt", 32'(i_gnt), 32'(ei));
        chk("d_gnt", 32'(d_gnt), 32'(ed));
        chk("mem_req", 32'(mem_req), 32'(em));
        chk("i_rvalid", 32'(i_rvalid), 32'(ri));
        chk("d_rvalid", 32'(d_rvalid), 32'(rd));
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_d(input logic err, input logic c, input logic [31:0] data);
        d_resp_t e;
        e.err = err; e.chk = c; e.data = data;
        d_exp.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] i_turn;
        reset = 1'b1;
        idle_inputs();
        #2;
        chk("rst_i_rvalid", 32'(i_rvalid), 32'h0);
        chk("rst_d_rvalid", 32'(d_rvalid), 32'h0);
        chk("rst_d_err", 32'(d_err), 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        next_cyc();
        reset = 1'b0;

        for (int k = 0; k < 5; k++) begin
            at_neg(0, 0, 0, 0, 0);
            chk("idle_mem_we", 32'(mem_we), 32'h0);
            next_cyc();
        end

        i_req = 1; i_addr = 32'h10;
        at_neg(1, 0, 1, 0, 0);
        chk("i_mem_addr", mem_addr, 32'h10);
        chk("i_mem_f3", 32'(mem_f3), 32'h2);
        chk("i_mem_we", 32'(mem_we), 32'h0);
        chk("i_mem_wdata", mem_wdata, 32'h0);
        i_exp.push_back(32'hDEADBEEF);
        next_cyc();
        idle_inputs();
        at_neg(0, 0, 0, 1, 0);
        next_cyc();

        // Both requesting: D wins 4 times, I forced on the 5th, repeating
        i_turn = 10'b1000010000;
        i_req = 1; i_addr = 32'h40;
        d_req = 1; d_we = 0; d_f3 = 3'b010; d_addr = 32'h80;
        for (int k = 0; k < 10; k++) begin
            at_neg(i_turn[k], !i_turn[k], 1, (k > 0) && i_turn[(k + 9) % 10],
                   (k > 0) && !i_turn[(k + 9) % 10]);
            chk("starve_mem_addr", mem_addr, i_turn[k] ? 32'h40 : 32'h80);
            if (i_turn[k]) i_exp.push_back(32'h0040FFBF);
            else push_d(0, 1, 32'h0080FF7F);
            next_cyc();
        end
        idle_inputs();
        at_neg(0, 0, 0, 1, 0);
        next_cyc();

        i_req = 1; i_addr = 32'h20;
        d_req = 1; d_we = 1; d_f3 = 3'b010; d_addr = 32'h6; d_wdata = 32'h1234_5678;
        at_neg(1, 1, 1, 0, 0);
        chk("mis_mem_addr", mem_addr, 32'h20);
        chk("mis_mem_we", 32'(mem_we), 32'h0);
        i_exp.push_back(32'h0020FFDF);
        push_d(1, 1, 32'h0);
        next_cyc();
        idle_inputs();
        at_neg(0, 0, 0, 1, 1);
        next_cyc();

        d_req = 1; d_f3 = 3'b001; d_addr = 32'h1;
        at_neg(0, 1, 0, 0, 0);
        push_d(1, 1, 32'h0);
        next_cyc();
        d_f3 = 3'b101; d_addr = 32'h3;
        at_neg(0, 1, 0, 0, 1);
        push_d(1, 1, 32'h0);
        next_cyc();
        idle_inputs();
        at_neg(0, 0, 0, 0, 1);
        next_cyc();

        d_req = 1; d_we = 1; d_f3 = 3'b000; d_addr = 32'h3; d_wdata = 32'h5A;
        at_neg(0, 1, 1, 0, 0);
        chk("sb_mem_we", 32'(mem_we), 32'h1);
        chk("sb_mem_f3", 32'(mem_f3), 32'h0);
        chk("sb_mem_addr", mem_addr, 32'h3);
        chk("sb_mem_wdata", mem_wdata, 32'h5A);
        push_d(0, 0, 32'h0);
        next_cyc();
        d_we = 0; d_f3 = 3'b001; d_addr = 32'h2; d_wdata = 0;
        at_neg(0, 1, 1, 0, 1);
        chk("lh_mem_we", 32'(mem_we), 32'h0);
        chk("lh_mem_f3", 32'(mem_f3), 32'h1);
        chk("lh_mem_addr", mem_addr, 32'h2);
        push_d(0, 1, 32'h0002FFFD);
        next_cyc();
        idle_inputs();
        at_neg(0, 0, 0, 0, 1);
        next_cyc();

        d_req = 1; d_f3 = 3'b010; d_addr = 32'h100;
        at_neg(0, 1, 1, 0, 0);
        push_d(0, 1, 32'h0100FEFF);
        next_cyc();
        idle_inputs();
        reset = 1'b1;
        #1;
        chk("rst_kill_d_rvalid", 32'(d_rvalid), 32'h0);
        d_exp.delete();
        next_cyc();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            at_neg(0, 0, 0, 0, 0);
            next_cyc();
        end

        chk("queues_empty", 32'(i_exp.size() + d_exp.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port data memory between two requesters: the instruction-fetch port (I) and the load/store port (D).
- Arbitrates one access per cycle and steers the memory's 1-cycle-latency read data back to the port that issued the access.
- Detects misaligned D accesses and answers them with an error instead of touching memory.
- Load sign/zero extension stays outside this block; memory read data is passed through unmodified.

Parameters:
STARVE_LIMIT, 4, consecutive cycles I may lose arbitration while requesting before it is forced to win (1..15).

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
i_req  input  1  instruction-fetch request
i_addr  input  32  fetch address (word-aligned by contract)
i_gnt  output  1  I request accepted this cycle (combinational)
i_rvalid  output  1  I read data valid (cycle after i_gnt)
i_rdata  output  32  I read data
d_req  input  1  load/store request
d_we  input  1  1 = store, 0 = load
d_f3  input  3  RV32I funct3 size code (byte/half/word, unsigned variants)
d_addr  input  32  byte address
d_wdata  input  32  store data, LSB-aligned
d_gnt  output  1  D request accepted this cycle (combinational)
d_rvalid  output  1  D response valid (cycle after d_gnt, loads and stores)
d_rdata  output  32  D read data
d_err  output  1  misaligned-access error, qualifies d_rvalid
mem_req  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_f3  output  3  size code to memory
mem_addr  output  32  address to memory
mem_wdata  output  32  write data to memory
mem_rdata  input  32  memory read data, valid the cycle after mem_req

Behaviour:
- Reset (async): i_rvalid=0, d_rvalid=0, d_err=0, owner=NONE, starve_cnt=0.
  - Combinational outputs follow inputs; with no requests, mem_req=0 and both grants are 0.
  - Reset mid-access drops the pending response; no rvalid follows.
- Misalignment check (combinational on D):
  - mis = (f3[1:0]==2'b10 && addr[1:0]!=0) || (f3[1:0]==2'b01 && addr[0]).
  - Byte accesses are never misaligned.
- Arbitration, every cycle, fully pipelined (a new grant is allowed in the same cycle a response returns):
  - d_req && mis: d_gnt=1 and memory untouched. I may be granted in the same cycle if i_req.
  - d_req && !mis && i_req: D wins unless starve_cnt==STARVE_LIMIT, in which case I wins.
  - Exactly one valid requester: it wins.
  - The winner gets gnt=1. mem_req=1 with the winner's addr/we/f3/wdata.
  - For I: mem_we=0, mem_f3=3'b010, mem_wdata=0.
  - With no winner, mem_we=0 (other mem fields don't-care).
- starve_cnt:
  - Increments when i_req && !i_gnt, saturating at STARVE_LIMIT.
  - Clears when i_gnt or !i_req.
- owner register: I, D or NONE, capturing this cycle's memory winner. A D-error grant sets a separate err_pend flag.
- Response cycle (one cycle after grant):
  - owner==I: i_rvalid=1, i_rdata=mem_rdata.
  - owner==D: d_rvalid=1, d_rdata=mem_rdata, d_err=0. Also asserted for stores; d_rdata is then don't-care.
  - err_pend: d_rvalid=1, d_err=1, d_rdata=0.
  - Otherwise the corresponding rvalid=0, rdata=0.
  - At most one D response per cycle. A misaligned D and a memory D cannot both be granted in one cycle.
- Requesters hold req and fields stable until gnt. Deasserting req before gnt cancels the request with no side effect.

Test Plan:
- Reset then idle, i_req=d_req=0 for 5 cycles -> mem_req=0, all rvalid=0, starve_cnt=0.
- i_req only, i_addr=0x10, mem_rdata=0xDEADBEEF next cycle -> i_gnt=1 with mem_addr=0x10, mem_f3=010, mem_we=0; following cycle i_rvalid=1, i_rdata=0xDEADBEEF.
- i_req and d_req held high continuously, STARVE_LIMIT=4 -> D granted 4 cycles, I granted on the 5th, then D resumes; no cycle with two memory grants.
- d_req, d_we=1, d_f3=010, d_addr=0x6 plus i_req, i_addr=0x20 -> same cycle d_gnt=1, i_gnt=1, mem_addr=0x20; next cycle d_rvalid=1, d_err=1, d_rdata=0 and i_rvalid=1.
- D store SB at 0x3, then D load LH at 0x2 back-to-back -> two consecutive d_gnt, mem_req both cycles, d_rvalid on cycles 2 and 3, d_err=0.
- Grant D load, assert reset in the response cycle -> d_rvalid=0 immediately; after release owner=NONE and no late response.
